uart_packet_parser: RTL and testbench
=====================================

# uart_packet_parser

Front-end stage between the UART receiver and the ALU. Consumes the received byte stream, frames it into command packets (opcode, length, payload), assembles payload bytes into 32-bit operand words, and issues them to the ALU with a one-cycle start pulse. It respects the ALU busy flag and flags malformed packets and byte overruns.

## Interface
Parameters:
- MAX_LEN, 16'hFFFF, largest accepted packet length in bytes, header included.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe; rx_data_i valid.
- alu_busy_i  in  1  ALU busy flag, registered inside the ALU.
- opcode_o  out  8  opcode of the operand set being issued.
- top_byte_o  out  2  valid bytes in data1_o, mod 4 (0 = 4). Used for echo only; 0 otherwise.
- data1_o  out  33  first operand, zero-extended; bit 32 = 0.
- data1_valid_o  out  1  data1_o valid; asserted with start_alu_o.
- data2_o  out  33  second operand, zero-extended.
- data2_valid_o  out  1  data2_o valid; asserted with start_alu_o for arithmetic opcodes only.
- start_alu_o  out  1  one-cycle issue pulse.
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  cause of the last error, held: 1 bad opcode, 2 bad length, 3 overrun.

## Operation
- Packet format: byte0 = opcode; byte1 = reserved, ignored; byte2/byte3 = length, little-endian, counted over the whole packet; then payload of (length−4) bytes.
- Valid opcodes: 8'hEC echo, 8'hAD add, 8'hAC multiply, 8'hD1 divide.
- Length rules:
  - Arithmetic opcodes require length == 12.
  - Echo requires 5 ≤ length ≤ MAX_LEN.
- Receive FSM: OPC → RSV → LEN_LO → LEN_HI → PAYLOAD, or DISCARD on error. States advance only on rx_valid_i.
  - At LEN_HI, the opcode and length are checked:
    - Bad opcode: err code 1.
    - Bad length: err code 2.
    - Bad opcode takes priority over bad length.
    - On error: if length > 4, go to DISCARD and drop (length−4) bytes, then return to OPC. Otherwise return to OPC directly.
  - PAYLOAD: a 16-bit remaining-byte counter tracks the payload. Bytes pack little-endian: first byte → bits [7:0].
    - Echo: a word completes after 4 bytes, or when the final payload byte arrives. top_byte = byte count mod 4.
    - Arithmetic: word 0 → data1, word 1 → data2. The set completes on byte 8.
    - After the last payload byte, return to OPC.
- Hand-off: a completed set is copied to a pending buffer (pending = 1), and assembly continues.
  - If a set completes while pending = 1: the overflowing set is dropped, err code 3 is raised, and the receive FSM goes to DISCARD for the rest of the packet.
- Issue FSM:
  - I_IDLE: if pending and !alu_busy_i, load the output registers, pulse start_alu_o plus valids, clear pending, go to I_HOLD.
  - I_HOLD: lasts 1 cycle, covering the ALU's registered busy. Then go to I_WAIT.
  - I_WAIT: wait until alu_busy_i = 0, then go to I_IDLE.
- Output registers (opcode_o, top_byte_o, data*_o) hold their values until the next issue.
- Simultaneous events:
  - rx_valid_i completing a set in the same cycle the issue FSM consumes pending: accepted, no overrun.
  - Error detection and a start pulse in the same cycle: both occur.

## Timing
- Reset: every output is 0; both FSMs go to their idle states (OPC, I_IDLE); pending = 0; counters = 0. Reset mid-packet abandons the packet with no error pulse.
- Latency: final byte of a set strobed at cycle N → start_alu_o at N+1 if the issue FSM is in I_IDLE and alu_busy_i = 0.
- start_alu_o, data1_valid_o, data2_valid_o, and err_o are single-cycle pulses.
- err_o fires the cycle after the offending byte. err_code_o updates in the same cycle and is held.
- Minimum spacing between start pulses is 3 cycles (issue, hold, wait with idle busy).
- rx_valid_i may arrive on consecutive cycles; no byte is lost except as defined for overrun.

## Test plan
- Add: bytes AD,00,0C,00,01,00,00,00,02,00,00,00 → one start pulse; data1_o = 1, data2_o = 2, both valids = 1, opcode_o = AD, top_byte_o = 0.
- Echo of 5 bytes: EC,00,09,00,11,22,33,44,55, with the ALU busy for 20 cycles after each start → first start with data1_o = 44332211, top_byte_o = 0. Second start, after busy falls, with data1_o = 55, top_byte_o = 1. data2_valid_o = 0 on both.
- Bad opcode: 7F,00,06,00,AA,BB followed by a valid add packet → err_o pulse, err_code_o = 1, AA/BB discarded, the add is issued correctly.
- Bad length: AC,00,08,00 plus 4 bytes → err_code_o = 2, no start pulse. Length 3 → err, next byte parsed as an opcode.
- Overrun: echo of 12 payload bytes with alu_busy_i held high throughout → first word pending, second completes → err_code_o = 3, rest discarded. One start pulse when busy drops.
- Reset low mid-payload → all outputs 0 immediately. After release, a fresh add packet issues normally.

Source files
------------

// File: rtl/uart_packet_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_packet_parser
// Brief    : Frames the UART byte stream into command packets. Assembles the
//            payload into 32-bit operands and issues them to the ALU with a
//            start pulse, honouring ALU busy. Flags bad packets and overruns.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_parser #(
    parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        alu_busy_i,
    output logic [7:0]  opcode_o,
    output logic [1:0]  top_byte_o,
    output logic [32:0] data1_o,
    output logic        data1_valid_o,
    output logic [32:0] data2_o,
    output logic        data2_valid_o,
    output logic        start_alu_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam logic [7:0]  c_OP_ECHO  = 8'hEC;
    localparam logic [7:0]  c_OP_ADD   = 8'hAD;
    localparam logic [7:0]  c_OP_MUL   = 8'hAC;
    localparam logic [7:0]  c_OP_DIV   = 8'hD1;
    localparam logic [15:0] c_HDR_LEN  = 16'd4;
    localparam logic [15:0] c_ARI_LEN  = 16'd12;
    localparam logic [15:0] c_ECHO_MIN = 16'd5;
    localparam logic [1:0]  c_ERR_OPC  = 2'd1;
    localparam logic [1:0]  c_ERR_LEN  = 2'd2;
    localparam logic [1:0]  c_ERR_OVR  = 2'd3;

    typedef enum logic [2:0] {
        S_OPC     = 3'd0,
        S_RSV     = 3'd1,
        S_LEN_LO  = 3'd2,
        S_LEN_HI  = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DISCARD = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_HOLD = 2'd1,
        I_WAIT = 2'd2
    } is_state_t;

    // Receive-side registers
    rx_state_t   r_rx_state;
    logic [7:0]  r_opc;
    logic [7:0]  r_len_lo;
    logic [15:0] r_rem;
    logic [31:0] r_word;
    logic [1:0]  r_bcnt;
    logic        r_widx;
    logic [31:0] r_d1acc;

    // Pending hand-off buffer and issue FSM
    logic        r_pend;
    logic [7:0]  r_p_opc;
    logic [1:0]  r_p_top;
    logic [31:0] r_p_d1;
    logic [31:0] r_p_d2;
    logic        r_p_d2v;
    is_state_t   r_is_state;

    // Receive next-state and completed-set signals
    rx_state_t   w_rx_next;
    logic [7:0]  w_opc_nx;
    logic [7:0]  w_len_lo_nx;
    logic [15:0] w_rem_nx;
    logic [31:0] w_word_nx;
    logic [1:0]  w_bcnt_nx;
    logic        w_widx_nx;
    logic [31:0] w_d1acc_nx;
    logic        w_set_done;
    logic        w_accept;
    logic [1:0]  w_set_top;
    logic [31:0] w_set_d1;
    logic [31:0] w_set_d2;
    logic        w_set_d2v;
    logic        w_err;
    logic [1:0]  w_err_code;

    // Issue-side combinational signals
    is_state_t   w_is_next;
    logic        w_issue;
    logic        w_consume;
    logic        w_load_pend;
    logic [7:0]  w_src_opc;
    logic [1:0]  w_src_top;
    logic [31:0] w_src_d1;
    logic [31:0] w_src_d2;
    logic        w_src_d2v;

    logic        w_is_echo;
    logic        w_is_arith;
    logic [15:0] w_len;
    logic        w_last;
    logic [31:0] w_word_next;

    assign w_is_echo   = (r_opc == c_OP_ECHO);
    assign w_is_arith  = (r_opc == c_OP_ADD) || (r_opc == c_OP_MUL) || (r_opc == c_OP_DIV);
    assign w_len       = {rx_data_i, r_len_lo};
    assign w_last      = (r_rem == 16'd1);
    assign w_word_next = r_word | ({24'd0, rx_data_i} << {r_bcnt, 3'b000});

    // The buffered set leaves this cycle, so a newly completed set can take its place
    assign w_consume   = (r_is_state == I_IDLE) && r_pend && !alu_busy_i;

    // Receive FSM: next state, payload assembly, error detection
    always_comb begin
        w_rx_next   = r_rx_state;
        w_opc_nx    = r_opc;
        w_len_lo_nx = r_len_lo;
        w_rem_nx    = r_rem;
        w_word_nx   = r_word;
        w_bcnt_nx   = r_bcnt;
        w_widx_nx   = r_widx;
        w_d1acc_nx  = r_d1acc;
        w_set_done  = 1'b0;
        w_accept    = 1'b0;
        w_set_top   = 2'd0;
        w_set_d1    = 32'd0;
        w_set_d2    = 32'd0;
        w_set_d2v   = 1'b0;
        w_err       = 1'b0;
        w_err_code  = 2'd0;
        if (rx_valid_i) begin
            case (r_rx_state)
                S_OPC: begin
                    w_opc_nx  = rx_data_i;
                    w_rx_next = S_RSV;
                end
                S_RSV: begin
                    w_rx_next = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_len_lo_nx = rx_data_i;
                    w_rx_next   = S_LEN_HI;
                end
                S_LEN_HI: begin
                    w_word_nx = 32'd0;
                    w_bcnt_nx = 2'd0;
                    w_widx_nx = 1'b0;
                    w_rem_nx  = w_len - c_HDR_LEN;
                    if (!w_is_echo && !w_is_arith) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_OPC;
                    end else if ((w_is_arith && (w_len != c_ARI_LEN)) ||
                                 (w_is_echo && ((w_len < c_ECHO_MIN) || (w_len > MAX_LEN)))) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_LEN;
                    end
                    if (!w_err) begin
                        w_rx_next = S_PAYLOAD;
                    end else if (w_len > c_HDR_LEN) begin
                        w_rx_next = S_DISCARD;
                    end else begin
                        w_rem_nx  = 16'd0;
                        w_rx_next = S_OPC;
                    end
                end
                S_PAYLOAD: begin
                    w_rem_nx  = r_rem - 16'd1;
                    w_bcnt_nx = r_bcnt + 2'd1;
                    w_word_nx = w_word_next;
                    if (w_is_echo) begin
                        if ((r_bcnt == 2'd3) || w_last) begin
                            w_set_done = 1'b1;
                            w_set_d1   = w_word_next;
                            w_set_top  = r_bcnt + 2'd1;
                            w_word_nx  = 32'd0;
                        end
                    end else if (r_bcnt == 2'd3) begin
                        w_word_nx = 32'd0;
                        if (!r_widx) begin
                            w_d1acc_nx = w_word_next;
                            w_widx_nx  = 1'b1;
                        end else begin
                            w_set_done = 1'b1;
                            w_set_d1   = r_d1acc;
                            w_set_d2   = w_word_next;
                            w_set_d2v  = 1'b1;
                        end
                    end
                    w_rx_next = w_last ? S_OPC : S_PAYLOAD;
                    // Buffer still occupied and not leaving: drop this set and the packet tail
                    if (w_set_done && r_pend && !w_consume) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_OVR;
                        w_rx_next  = w_last ? S_OPC : S_DISCARD;
                    end else begin
                        w_accept = w_set_done;
                    end
                end
                S_DISCARD: begin
                    w_rem_nx = r_rem - 16'd1;
                    if (w_last) begin
                        w_rx_next = S_OPC;
                    end
                end
                default: begin
                    w_rx_next = S_OPC;
                end
            endcase
        end
    end

    // Receive FSM state and assembly registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= S_OPC;
            r_opc      <= 8'd0;
            r_len_lo   <= 8'd0;
            r_rem      <= 16'd0;
            r_word     <= 32'd0;
            r_bcnt     <= 2'd0;
            r_widx     <= 1'b0;
            r_d1acc    <= 32'd0;
        end else begin
            r_rx_state <= w_rx_next;
            r_opc      <= w_opc_nx;
            r_len_lo   <= w_len_lo_nx;
            r_rem      <= w_rem_nx;
            r_word     <= w_word_nx;
            r_bcnt     <= w_bcnt_nx;
            r_widx     <= w_widx_nx;
            r_d1acc    <= w_d1acc_nx;
        end
    end

    // Issue source: the buffered set first, else a set completing right now
    assign w_src_opc = r_pend ? r_p_opc : r_opc;
    assign w_src_top = r_pend ? r_p_top : w_set_top;
    assign w_src_d1  = r_pend ? r_p_d1  : w_set_d1;
    assign w_src_d2  = r_pend ? r_p_d2  : w_set_d2;
    assign w_src_d2v = r_pend ? r_p_d2v : w_set_d2v;

    // A fresh set bypassing an empty buffer straight to the ALU is not stored
    assign w_load_pend = w_accept && !(w_issue && !r_pend);

    // Issue FSM: next state and start decision
    always_comb begin
        w_is_next = r_is_state;
        w_issue   = 1'b0;
        case (r_is_state)
            I_IDLE: begin
                if (!alu_busy_i && (r_pend || w_accept)) begin
                    w_issue   = 1'b1;
                    w_is_next = I_HOLD;
                end
            end
            I_HOLD: begin
                w_is_next = I_WAIT;
            end
            I_WAIT: begin
                if (!alu_busy_i) begin
                    w_is_next = I_IDLE;
                end
            end
            default: begin
                w_is_next = I_IDLE;
            end
        endcase
    end

    // Issue FSM state, pending buffer and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_state    <= I_IDLE;
            r_pend        <= 1'b0;
            r_p_opc       <= 8'd0;
            r_p_top       <= 2'd0;
            r_p_d1        <= 32'd0;
            r_p_d2        <= 32'd0;
            r_p_d2v       <= 1'b0;
            opcode_o      <= 8'd0;
            top_byte_o    <= 2'd0;
            data1_o       <= 33'd0;
            data2_o       <= 33'd0;
            data1_valid_o <= 1'b0;
            data2_valid_o <= 1'b0;
            start_alu_o   <= 1'b0;
            err_o         <= 1'b0;
            err_code_o    <= 2'd0;
        end else begin
            r_is_state <= w_is_next;
            if (w_load_pend) begin
                r_pend  <= 1'b1;
                r_p_opc <= r_opc;
                r_p_top <= w_set_top;
                r_p_d1  <= w_set_d1;
                r_p_d2  <= w_set_d2;
                r_p_d2v <= w_set_d2v;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end
            start_alu_o   <= w_issue;
            data1_valid_o <= w_issue;
            data2_valid_o <= w_issue && w_src_d2v;
            if (w_issue) begin
                opcode_o   <= w_src_opc;
                top_byte_o <= w_src_top;
                data1_o    <= {1'b0, w_src_d1};
                data2_o    <= {1'b0, w_src_d2};
            end
            err_o <= w_err;
            if (w_err) begin
                err_code_o <= w_err_code;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_parser
// Brief    : Table-driven packet vectors with a scoreboard of expected ALU
//            issues and errors, plus hand-written overrun and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;

    typedef struct packed {
        logic [7:0]  opc;
        logic [1:0]  top;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        d2v;
    } iss_t;

    typedef struct packed {
        logic [159:0] b;      // packet bytes, right-aligned, first byte most significant
        logic [7:0]   n;
        logic [7:0]   busy;
        logic [1:0]   n_iss;
        iss_t         iss0;
        iss_t         iss1;
        logic [1:0]   err;
        logic         lat;    // start must follow the final byte by one cycle
    } vec_t;

    localparam int c_NVEC = 14;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        alu_busy;
    logic [7:0]  opcode_o;
    logic [1:0]  top_byte_o;
    logic [32:0] data1_o;
    logic        data1_valid_o;
    logic [32:0] data2_o;
    logic        data2_valid_o;
    logic        start_alu_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int          n_checks;
    int          n_fail;
    logic        force_busy;
    int          busy_len;
    int          busy_cnt;
    logic        prev_start;
    iss_t        exp_q[$];
    logic [1:0]  err_q[$];
    vec_t        vecs[c_NVEC];

    uart_packet_parser #(.MAX_LEN(16'hFFFF)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_i     (rx_data),
        .rx_valid_i    (rx_valid),
        .alu_busy_i    (alu_busy),
        .opcode_o      (opcode_o),
        .top_byte_o    (top_byte_o),
        .data1_o       (data1_o),
        .data1_valid_o (data1_valid_o),
        .data2_o       (data2_o),
        .data2_valid_o (data2_valid_o),
        .start_alu_o   (start_alu_o),
        .err_o         (err_o),
        .err_code_o    (err_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: busy rises the cycle after start and lasts busy_len cycles
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 0;
        end else if (start_alu_o) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign alu_busy = force_busy || (busy_cnt != 0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic iss_t mk_iss(logic [7:0] opc, logic [1:0] top, logic [31:0] d1,
                                    logic [31:0] d2, logic d2v);
        iss_t r;
        r.opc = opc; r.top = top; r.d1 = d1; r.d2 = d2; r.d2v = d2v;
        return r;
    endfunction

    function automatic vec_t mk_vec(logic [159:0] b, int n, int busy, int n_iss, iss_t i0,
                                    iss_t i1, logic [1:0] err, logic lat);
        vec_t v;
        v.b = b; v.n = 8'(n); v.busy = 8'(busy); v.n_iss = 2'(n_iss);
        v.iss0 = i0; v.iss1 = i1; v.err = err; v.lat = lat;
        return v;
    endfunction

    // Per-cycle scoreboard compare of start and error pulses
    task automatic monitor_sample();
        iss_t       e;
        logic [1:0] ec;
        if (!rst) begin
            prev_start = 1'b0;
            return;
        end
        chk("data1_valid tracks start", data1_valid_o, start_alu_o);
        chk("data2_valid outside start", data2_valid_o & ~start_alu_o, 0);
        if (start_alu_o) begin
            chk("start single-cycle", prev_start, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected start: opcode %0h data1 %0h, none expected", opcode_o, data1_o);
            end else begin
                e = exp_q.pop_front();
                chk("opcode", opcode_o, e.opc);
                chk("top_byte", top_byte_o, e.top);
                chk("data1", data1_o, {31'd0, e.d1});
                chk("data2", data2_o, {31'd0, e.d2});
                chk("data2_valid", data2_valid_o, e.d2v);
            end
        end
        if (err_o) begin
            if (err_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected err: code %0d, none expected", err_code_o);
            end else begin
                ec = err_q.pop_front();
                chk("err_code", err_code_o, ec);
            end
        end
        prev_start = start_alu_o;
    endtask

    task automatic send(input logic [159:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b[8*(n-1-i) +: 8];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic drain(input int lim);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0 || alu_busy) && i < lim) begin
            @(negedge clk);
            i++;
        end
        chk("drain within bound", (i < lim), 1);
        repeat (6) @(negedge clk);
        chk("no expected issue left", exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " opcode_o"}, opcode_o, 0);
        chk({tag, " top_byte_o"}, top_byte_o, 0);
        chk({tag, " data1_o"}, data1_o, 0);
        chk({tag, " data2_o"}, data2_o, 0);
        chk({tag, " data1_valid_o"}, data1_valid_o, 0);
        chk({tag, " data2_valid_o"}, data2_valid_o, 0);
        chk({tag, " start_alu_o"}, start_alu_o, 0);
        chk({tag, " err_o"}, err_o, 0);
        chk({tag, " err_code_o"}, err_code_o, 0);
    endtask

    initial begin
        iss_t none;
        none = '0;
        n_checks = 0; n_fail = 0;
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        force_busy = 1'b0; busy_len = 0; prev_start = 1'b0;

        vecs[0]  = mk_vec({8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h00,8'h00,8'h00,8'h02,8'h00,8'h00,8'h00}, 12, 3,
                          1, mk_iss(8'hAD, 2'd0, 32'h1, 32'h2, 1'b1), none, 2'd0, 1'b1);
        vecs[1]  = mk_vec({8'hEC,8'h00,8'h09,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55}, 9, 20,
                          2, mk_iss(8'hEC, 2'd0, 32'h44332211, 32'h0, 1'b0),
                          mk_iss(8'hEC, 2'd1, 32'h55, 32'h0, 1'b0), 2'd0, 1'b0);
        vecs[2]  = mk_vec({8'h7F,8'h00,8'h06,8'h00,8'hAA,8'hBB}, 6, 2, 0, none, none, 2'd1, 1'b0);
        vecs[3]  = mk_vec({8'hAD,8'h00,8'h0C,8'h00,8'h78,8'h56,8'h34,8'h12,8'hF0,8'hDE,8'hBC,8'h9A}, 12, 2,
                          1, mk_iss(8'hAD, 2'd0, 32'h12345678, 32'h9ABCDEF0, 1'b1), none, 2'd0, 1'b1);
        vecs[4]  = mk_vec({8'hAC,8'h00,8'h08,8'h00,8'h11,8'h22,8'h33,8'h44}, 8, 2, 0, none, none, 2'd2, 1'b0);
        vecs[5]  = mk_vec({8'hEC,8'h00,8'h03,8'h00}, 4, 2, 0, none, none, 2'd2, 1'b0);
        vecs[6]  = mk_vec({8'hAC,8'h00,8'h0C,8'h00,8'h05,8'h00,8'h00,8'h00,8'h07,8'h00,8'h00,8'h00}, 12, 2,
                          1, mk_iss(8'hAC, 2'd0, 32'h5, 32'h7, 1'b1), none, 2'd0, 1'b1);
        vecs[7]  = mk_vec({8'hD1,8'hFF,8'h0C,8'h00,8'h64,8'h00,8'h00,8'h00,8'h05,8'h00,8'h00,8'h00}, 12, 2,
                          1, mk_iss(8'hD1, 2'd0, 32'h64, 32'h5, 1'b1), none, 2'd0, 1'b1);
        vecs[8]  = mk_vec({8'hEC,8'h00,8'h08,8'h00,8'hDE,8'hAD,8'hBE,8'hEF}, 8, 2,
                          1, mk_iss(8'hEC, 2'd0, 32'hEFBEADDE, 32'h0, 1'b0), none, 2'd0, 1'b1);
        vecs[9]  = mk_vec({8'hEC,8'h00,8'h0A,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06}, 10, 0,
                          2, mk_iss(8'hEC, 2'd0, 32'h04030201, 32'h0, 1'b0),
                          mk_iss(8'hEC, 2'd2, 32'h0605, 32'h0, 1'b0), 2'd0, 1'b0);
        vecs[10] = mk_vec({8'h00,8'h00,8'h04,8'h00}, 4, 2, 0, none, none, 2'd1, 1'b0);
        vecs[11] = mk_vec({8'h12,8'h00,8'h02,8'h00}, 4, 2, 0, none, none, 2'd1, 1'b0);
        vecs[12] = mk_vec({8'hEC,8'h00,8'h05,8'h00,8'h7E}, 5, 2,
                          1, mk_iss(8'hEC, 2'd1, 32'h7E, 32'h0, 1'b0), none, 2'd0, 1'b1);
        vecs[13] = mk_vec({8'hAD,8'h00,8'h0D,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09}, 13, 2,
                          0, none, none, 2'd2, 1'b0);

        fork
            forever begin
                @(negedge clk);
                monitor_sample();
            end
        join_none

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven packets
        for (int v = 0; v < c_NVEC; v++) begin
            busy_len = int'(vecs[v].busy);
            if (vecs[v].n_iss >= 2'd1) exp_q.push_back(vecs[v].iss0);
            if (vecs[v].n_iss >= 2'd2) exp_q.push_back(vecs[v].iss1);
            if (vecs[v].err != 2'd0) err_q.push_back(vecs[v].err);
            send(vecs[v].b, int'(vecs[v].n));
            if (vecs[v].lat) chk($sformatf("vec%0d start latency", v), start_alu_o, 1);
            drain(200);
            if (vecs[v].err != 2'd0) chk($sformatf("vec%0d err_code held", v), err_code_o, vecs[v].err);
        end

        // Overrun: ALU busy throughout, second echo word finds the buffer full
        force_busy = 1'b1;
        busy_len   = 2;
        exp_q.push_back(mk_iss(8'hEC, 2'd0, 32'h04030201, 32'h0, 1'b0));
        err_q.push_back(2'd3);
        send({8'hEC,8'h00,8'h10,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,
              8'h07,8'h08,8'h09,8'h0A,8'h0B,8'h0C}, 16);
        repeat (5) @(negedge clk);
        chk("overrun err_code", err_code_o, 3);
        chk("no start while busy", exp_q.size(), 1);
        force_busy = 1'b0;
        drain(200);

        // Discarded tail must not be parsed: a following add issues normally
        exp_q.push_back(vecs[0].iss0);
        send(vecs[0].b, int'(vecs[0].n));
        drain(200);

        // Reset mid-payload abandons the packet and clears every output at once
        send({8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h02,8'h03}, 7);
        rst = 1'b0;
        #1;
        chk_all_zero("mid-packet reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(vecs[3].iss0);
        send(vecs[3].b, int'(vecs[3].n));
        chk("post-reset start latency", start_alu_o, 1);
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
